// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the flagged FIFO and its pointer sub-module:
//   read_mode_e  - read-port behaviour (STANDARD registered dout, or FWFT)
//   count_width  - bits needed to hold an occupancy of 0..depth
//   ptr_width    - bits needed to address depth storage words
// -----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        STANDARD = 1'b0,
        FWFT     = 1'b1
    } read_mode_e;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A 1-word FIFO would give $clog2 == 0; keep at least one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
// Storage pointer that advances by one on each cycle inc is high and wraps
// from DEPTH-1 back to 0, so DEPTH need not be a power of two.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, pointer to 0
//   inc  in   advance the pointer this cycle
//   ptr  out  current pointer, 0..DEPTH-1
// -----------------------------------------------------------------------------
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inc,
    output logic [ptr_width(DEPTH)-1:0]  ptr
);

    localparam int PW = ptr_width(DEPTH);

    // Explicit compare against the last index: natural binary overflow would
    // only wrap correctly for power-of-two depths.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PW'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_flagged.sv
// -----------------------------------------------------------------------------
// fifo_flagged
// Synchronous single-clock FIFO with occupancy count and full/empty,
// almost-full/almost-empty and overflow/underflow flags. The read port either
// registers dout on each accepted read (FWFT=0) or shows the head word
// combinationally whenever the FIFO is not empty (FWFT=1).
// Parameters: WIDTH, DEPTH (>=2), FWFT (0/1), AF_LEVEL (1..DEPTH),
//             AE_LEVEL (0..DEPTH-1).
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   din           in   write data
//   write         in   write request
//   full          out  count == DEPTH
//   almost_full   out  count >= AF_LEVEL
//   overflow      out  one-cycle pulse after a rejected write
//   read          in   read request
//   dout          out  read data
//   empty         out  count == 0
//   almost_empty  out  count <= AE_LEVEL
//   underflow     out  one-cycle pulse after a rejected read
//   count         out  stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               din,
    input  logic                           write,
    output logic                           full,
    output logic                           almost_full,
    output logic                           overflow,
    input  logic                           read,
    output logic [WIDTH-1:0]               dout,
    output logic                           empty,
    output logic                           almost_empty,
    output logic                           underflow,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int         CW   = count_width(DEPTH);
    localparam int         PW   = ptr_width(DEPTH);
    localparam read_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STANDARD;

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flagged: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flagged: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flagged: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
        $error("fifo_flagged: FWFT must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance is judged on the registered flags, so a write into a full
    // FIFO is rejected even when a read frees a word on the same edge, and a
    // read from an empty FIFO is rejected even alongside a write.
    assign wr_acc = write && !full;
    assign rd_acc = read && !empty;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write && full;
            underflow <= read && empty;
        end
    end

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Storage is not reset; the cleared pointers and count make any stale
    // contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    if (MODE == fifo_pkg::STANDARD) begin : g_std_read
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_ptr];
            end
        end

        assign dout = dout_q;
    end else begin : g_fwft_read
        assign dout = mem[rd_ptr];
    end

endmodule
